// File: rtl/switch_debounce_pkg.sv
// Shared constants and FSM state encoding for the switch debouncer.
// Also holds the 10 ms @ 12 MHz debounce constant reused by other board blocks.
package switch_debounce_pkg;

   localparam int DEBOUNCE_10MS_12MHZ = 120000;

   typedef enum logic [1:0] {
      ST_LOW      = 2'd0,
      ST_RISE_CHK = 2'd1,
      ST_HIGH     = 2'd2,
      ST_FALL_CHK = 2'd3
   } state_t;

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: synchroniser chain, stability counter and debounce FSM.
// Ports: clk, rst_n (async, active-low), sw_raw (pad), sw_level/sw_rise/sw_fall (registered).
module debounce_channel
   import switch_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic sw_level,
   output logic sw_rise,
   output logic sw_fall
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   state_t                 state_q, state_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   s;

   // Oldest sample sits in the top bit; only it reaches the FSM.
   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         ST_LOW: begin
            if (s) begin
               state_d = ST_RISE_CHK;
               cnt_d   = '0;
            end
         end
         ST_RISE_CHK: begin
            if (!s) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_d = ST_FALL_CHK;
               cnt_d   = '0;
            end
         end
         ST_FALL_CHK: begin
            if (s) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
      // Level is registered so it flips on the same edge as its strobe.
      level_d = (state_d == ST_HIGH) || (state_d == ST_FALL_CHK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         state_q <= ST_LOW;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign sw_level = level_q;
   assign sw_rise  = rise_q;
   assign sw_fall  = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Debounces N_CH mechanical switch pads into clean levels plus rise/fall strobes.
// Ports: clk, rst_n (async, active-low), sw_raw[N_CH], sw_level/sw_rise/sw_fall[N_CH].
module switch_debounce
   import switch_debounce_pkg::*;
#(
   parameter int N_CH            = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] sw_raw,
   output logic [N_CH-1:0] sw_level,
   output logic [N_CH-1:0] sw_rise,
   output logic [N_CH-1:0] sw_fall
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .sw_raw   (sw_raw[i]),
         .sw_level (sw_level[i]),
         .sw_rise  (sw_rise[i]),
         .sw_fall  (sw_fall[i])
      );
   end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=16, SYNC_STAGES=2, N_CH=2.
// Edge k=1 is the first posedge sampling a new pad value; level changes at k=19.
module tb_switch_debounce;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] sw_raw = 2'b00;
   logic [1:0] sw_level;
   logic [1:0] sw_rise;
   logic [1:0] sw_fall;

   int checks = 0;
   int errors = 0;

   switch_debounce #(
      .N_CH            (2),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_raw   (sw_raw),
      .sw_level (sw_level),
      .sw_rise  (sw_rise),
      .sw_fall  (sw_fall)
   );

   always #5 clk = ~clk;

   task automatic settle(input logic [1:0] pads);
      @(negedge clk);
      sw_raw = pads;
      repeat (25) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      sw_raw = 2'b00;
      #3;
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== 6'b0) begin
         errors++;
         $display("FAIL reset_async got %b want 000000",
                  {sw_level, sw_rise, sw_fall});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== 6'b0) begin
         errors++;
         $display("FAIL reset_idle got %b want 000000",
                  {sw_level, sw_rise, sw_fall});
      end
   endtask

   task automatic test_clean_rise();
      logic el, er;
      @(negedge clk);
      sw_raw[0] = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         @(posedge clk);
         #1;
         el = (k >= 19);
         er = (k == 19);
         checks++;
         if (sw_level[0] !== el || sw_rise[0] !== er || sw_fall[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_rise k=%0d got l=%b r=%b f=%b want l=%b r=%b f=0",
                     k, sw_level[0], sw_rise[0], sw_fall[0], el, er);
         end
      end
   endtask

   task automatic test_bounce();
      logic el, er;
      settle(2'b00);
      for (int seg = 0; seg < 4; seg++) begin
         @(negedge clk);
         sw_raw[0] = (seg % 2 == 0);
         for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (sw_level[0] !== 1'b0 || sw_rise[0] !== 1'b0 || sw_fall[0] !== 1'b0) begin
               errors++;
               $display("FAIL bounce seg=%0d got l=%b r=%b f=%b want 000",
                        seg, sw_level[0], sw_rise[0], sw_fall[0]);
            end
         end
      end
      @(negedge clk);
      sw_raw[0] = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         @(posedge clk);
         #1;
         el = (k >= 19);
         er = (k == 19);
         checks++;
         if (sw_level[0] !== el || sw_rise[0] !== er || sw_fall[0] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_rise k=%0d got l=%b r=%b f=%b want l=%b r=%b f=0",
                     k, sw_level[0], sw_rise[0], sw_fall[0], el, er);
         end
      end
   endtask

   task automatic test_clean_fall();
      logic el, ef;
      @(negedge clk);
      sw_raw[0] = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         @(posedge clk);
         #1;
         el = (k < 19);
         ef = (k == 19);
         checks++;
         if (sw_level[0] !== el || sw_fall[0] !== ef || sw_rise[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_fall k=%0d got l=%b r=%b f=%b want l=%b r=0 f=%b",
                     k, sw_level[0], sw_rise[0], sw_fall[0], el, ef);
         end
      end
   endtask

   task automatic test_glitch();
      logic el, er, ef;
      @(negedge clk);
      sw_raw[1] = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (sw_level !== 2'b00 || sw_rise !== 2'b00 || sw_fall !== 2'b00) begin
            errors++;
            $display("FAIL glitch15 k=%0d got l=%b r=%b f=%b want 00 00 00",
                     k, sw_level, sw_rise, sw_fall);
         end
         if (k == 15) sw_raw[1] = 1'b0;
      end
      @(negedge clk);
      sw_raw[1] = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         el = (k >= 19) && (k < 36);
         er = (k == 19);
         ef = (k == 36);
         checks++;
         if (sw_level !== {el, 1'b0} || sw_rise !== {er, 1'b0}
             || sw_fall !== {ef, 1'b0}) begin
            errors++;
            $display("FAIL glitch17 k=%0d got l=%b r=%b f=%b want l=%b r=%b f=%b",
                     k, sw_level, sw_rise, sw_fall, {el, 1'b0}, {er, 1'b0}, {ef, 1'b0});
         end
         if (k == 17) sw_raw[1] = 1'b0;
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] el, er;
      @(negedge clk);
      sw_raw = 2'b11;
      for (int k = 1; k <= 21; k++) begin
         @(posedge clk);
         #1;
         el = (k >= 19) ? 2'b11 : 2'b00;
         er = (k == 19) ? 2'b11 : 2'b00;
         checks++;
         if (sw_level !== el || sw_rise !== er || sw_fall !== 2'b00) begin
            errors++;
            $display("FAIL simultaneous k=%0d got l=%b r=%b f=%b want l=%b r=%b f=00",
                     k, sw_level, sw_rise, sw_fall, el, er);
         end
      end
      settle(2'b00);
      checks++;
      if (sw_level !== 2'b00) begin
         errors++;
         $display("FAIL simul_release got l=%b want 00", sw_level);
      end
   endtask

   task automatic test_reset_mid_check();
      logic [1:0] el, er;
      settle(2'b10);
      checks++;
      if (sw_level !== 2'b10) begin
         errors++;
         $display("FAIL rst_mid_pre got l=%b want 10", sw_level);
      end
      @(negedge clk);
      sw_raw = 2'b11;
      repeat (11) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== 6'b0) begin
         errors++;
         $display("FAIL rst_mid_async got %b want 000000",
                  {sw_level, sw_rise, sw_fall});
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== 6'b0) begin
         errors++;
         $display("FAIL rst_mid_hold got %b want 000000",
                  {sw_level, sw_rise, sw_fall});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         @(posedge clk);
         #1;
         el = (k >= 19) ? 2'b11 : 2'b00;
         er = (k == 19) ? 2'b11 : 2'b00;
         checks++;
         if (sw_level !== el || sw_rise !== er || sw_fall !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_rise k=%0d got l=%b r=%b f=%b want l=%b r=%b f=00",
                     k, sw_level, sw_rise, sw_fall, el, er);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_rise();
      test_bounce();
      test_clean_fall();
      test_glitch();
      test_simultaneous();
      test_reset_mid_check();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
